// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control path: opcodes, ALU/ImmExt codes,
// FSM states and the decoded-instruction record passed from decode to the FSM.
package multicycle_ctrl_fsm_pkg;

  localparam logic [5:0] OP_R    = 6'b100000;
  localparam logic [5:0] OP_LI   = 6'b111000;
  localparam logic [5:0] OP_LUI  = 6'b111001;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b010000;
  localparam logic [5:0] OP_BNE  = 6'b010001;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SW   = 6'b011111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [1:0] IMM_SEXT = 2'b00;
  localparam logic [1:0] IMM_ZEXT = 2'b01;
  localparam logic [1:0] IMM_HI   = 2'b10;

  typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB} state_t;
  typedef enum logic [2:0] {CL_ALU, CL_BR, CL_LW, CL_SW, CL_ILL} op_class_t;
  typedef enum logic [1:0] {BR_ALWAYS, BR_EQ, BR_NE} br_kind_t;

  typedef struct packed {
    op_class_t  cls;
    br_kind_t   br;
    logic [3:0] alu_func;
    logic       bin_sel;
    logic [1:0] imm_ext;
    logic       rf_b_sel;
  } dec_t;

  function automatic logic take_branch(br_kind_t br, logic zero);
    case (br)
      BR_EQ:   return zero;
      BR_NE:   return ~zero;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the control FSM (master) and the datapath/ALU stage (slave).
interface multicycle_ctrl_fsm_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        Instr_LdEn;
  logic        PC_LdEn;
  logic        PC_sel;
  logic [1:0]  ImmExt;
  logic        RF_B_sel;
  logic        ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        Mem_En;
  logic        Mem_WrEn;
  logic        RF_WrEn;
  logic        RF_WrData_sel;
  logic        Illegal_op;

  modport master (
    input  Instr, Zero,
    output Instr_LdEn, PC_LdEn, PC_sel, ImmExt, RF_B_sel, ALU_Bin_sel, ALU_func,
           Mem_En, Mem_WrEn, RF_WrEn, RF_WrData_sel, Illegal_op
  );

  modport slave (
    output Instr, Zero,
    input  Instr_LdEn, PC_LdEn, PC_sel, ImmExt, RF_B_sel, ALU_Bin_sel, ALU_func,
           Mem_En, Mem_WrEn, RF_WrEn, RF_WrData_sel, Illegal_op
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_decode.sv
// Combinational opcode/func decode into instruction class and ALU-stage controls.
module multicycle_ctrl_fsm_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [3:0] func,
  output dec_t       dec
);

  always_comb begin
    dec = '{cls: CL_ILL, br: BR_ALWAYS, alu_func: ALU_ADD, bin_sel: 1'b0,
            imm_ext: IMM_SEXT, rf_b_sel: 1'b0};
    case (opcode)
      OP_R:    begin dec.cls = CL_ALU; dec.alu_func = func; end
      OP_LI,
      OP_ADDI: begin dec.cls = CL_ALU; dec.bin_sel = 1'b1; end
      OP_LUI:  begin dec.cls = CL_ALU; dec.bin_sel = 1'b1; dec.imm_ext = IMM_HI; end
      OP_ANDI: begin
        dec.cls = CL_ALU; dec.alu_func = ALU_AND; dec.bin_sel = 1'b1; dec.imm_ext = IMM_ZEXT;
      end
      OP_ORI:  begin
        dec.cls = CL_ALU; dec.alu_func = ALU_OR; dec.bin_sel = 1'b1; dec.imm_ext = IMM_ZEXT;
      end
      OP_B:    dec.cls = CL_BR;
      OP_BEQ:  begin
        dec.cls = CL_BR; dec.br = BR_EQ; dec.alu_func = ALU_SUB; dec.rf_b_sel = 1'b1;
      end
      OP_BNE:  begin
        dec.cls = CL_BR; dec.br = BR_NE; dec.alu_func = ALU_SUB; dec.rf_b_sel = 1'b1;
      end
      OP_LW:   begin dec.cls = CL_LW; dec.bin_sel = 1'b1; end
      OP_SW:   begin dec.cls = CL_SW; dec.bin_sel = 1'b1; dec.rf_b_sel = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a MEM_LAT-cycle MEM phase.
// Outputs are combinational from state and the opcode/func captured at the end of FETCH.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  multicycle_ctrl_fsm_if.master bus
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic [5:0] opcode_q;
  logic [3:0] func_q;
  logic [3:0] mem_cnt, mem_cnt_nxt;
  dec_t       dec;

  logic unused_instr;
  assign unused_instr = ^bus.Instr[25:4];

  multicycle_ctrl_fsm_decode u_decode (
    .opcode (opcode_q),
    .func   (func_q),
    .dec    (dec)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_FETCH;
      opcode_q <= '0;
      func_q   <= '0;
      mem_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      mem_cnt <= mem_cnt_nxt;
      if (state == ST_FETCH) begin
        opcode_q <= bus.Instr[31:26];
        func_q   <= bus.Instr[3:0];
      end
    end
  end

  always_comb begin
    state_nxt         = state;
    mem_cnt_nxt       = mem_cnt;
    bus.Instr_LdEn    = 1'b0;
    bus.PC_LdEn       = 1'b0;
    bus.PC_sel        = 1'b0;
    bus.ImmExt        = IMM_SEXT;
    bus.RF_B_sel      = 1'b0;
    bus.ALU_Bin_sel   = 1'b0;
    bus.ALU_func      = ALU_ADD;
    bus.Mem_En        = 1'b0;
    bus.Mem_WrEn      = 1'b0;
    bus.RF_WrEn       = 1'b0;
    bus.RF_WrData_sel = 1'b0;
    bus.Illegal_op    = 1'b0;

    // Everything stays quiet in a reset cycle so an aborted instruction leaves no side effects.
    if (!Reset) begin
      if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
        bus.ALU_func    = dec.alu_func;
        bus.ALU_Bin_sel = dec.bin_sel;
        bus.ImmExt      = dec.imm_ext;
      end

      case (state)
        ST_FETCH: begin
          bus.Instr_LdEn = 1'b1;
          state_nxt      = ST_DECODE;
        end
        ST_DECODE: begin
          bus.RF_B_sel = dec.rf_b_sel;
          if (dec.cls == CL_ILL) begin
            bus.Illegal_op = 1'b1;
            bus.PC_LdEn    = 1'b1;
            state_nxt      = ST_FETCH;
          end else begin
            state_nxt = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (dec.cls)
            CL_ALU:       state_nxt = ST_WB;
            CL_LW, CL_SW: state_nxt = ST_MEM;
            CL_BR: begin
              bus.PC_LdEn = 1'b1;
              bus.PC_sel  = take_branch(dec.br, bus.Zero);
              state_nxt   = ST_FETCH;
            end
            default:      state_nxt = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          bus.Mem_En = 1'b1;
          if (mem_cnt == MEM_LAST) begin
            mem_cnt_nxt = '0;
            if (dec.cls == CL_SW) begin
              bus.Mem_WrEn = 1'b1;
              bus.PC_LdEn  = 1'b1;
              state_nxt    = ST_FETCH;
            end else begin
              state_nxt = ST_WB;
            end
          end else begin
            mem_cnt_nxt = mem_cnt + 4'd1;
          end
        end
        ST_WB: begin
          bus.RF_WrEn       = 1'b1;
          bus.RF_WrData_sel = (dec.cls == CL_LW);
          bus.PC_LdEn       = 1'b1;
          state_nxt         = ST_FETCH;
        end
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

endmodule
